bram_responder: RTL and testbench

- Synthesizable memory-side responder for the 32-bit BRAM port driven by pe_con, replacing the behavioural memory model in hardware builds.
- Port A serves pe_con's reads and byte-masked writes with fixed read latency.
- Port B is a host side: it preloads operands before start and, on a rising edge of done, streams the result region out over a valid/ready interface.

---
 rtl/bram_responder_pkg.sv | 22 ++
 rtl/bram_skid_buffer.sv | 78 +++++++
 rtl/bram_responder.sv | 189 ++++++++++++++++++
 tb/tb_bram_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_responder_pkg.sv
// Shared definitions for the BRAM responder.
//   DATA_W      : BRAM data width (32)
//   BYTE_LANES  : byte write-enable lanes per word (4)
//   dump_state_e: dump FSM state encoding
//   word_index  : byte address -> 32-bit word index
package bram_responder_pkg;

  localparam int DATA_W     = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DUMP  = 2'd1,
    ST_DRAIN = 2'd2
  } dump_state_e;

  // Drops the two byte-offset bits; callers size-cast to their index width.
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return 30'(byte_addr >> 2);
  endfunction

endpackage

// File: rtl/bram_skid_buffer.sv
// Two-entry valid/ready buffer with a registered output stage.
//   clk, rst   : clock, synchronous active-high reset (empties the buffer)
//   in_valid   : push strobe; the producer guarantees count < 2 before the
//                push lands (it tracks count plus its own in-flight word)
//   in_data    : pushed word
//   out_valid  : output word valid
//   out_ready  : consumer accepts the output word this cycle
//   out_data   : output word, stable while out_valid & ~out_ready
//   count      : number of words held (0..2)
module bram_skid_buffer
  import bram_responder_pkg::*;
#(
  parameter int WIDTH = DATA_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             pop;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    pop        = out_vld_q & out_ready;
    if (!out_vld_q || pop) begin
      // Output slot frees up: the older skid word moves forward first so
      // ordering is preserved, and any incoming word takes its place.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = in_valid;
        skid_dat_d = in_data;
      end else begin
        out_vld_d = in_valid;
        if (in_valid) begin
          out_dat_d = in_data;
        end
      end
    end else if (in_valid && !skid_vld_q) begin
      // Output is stalled; park the new word in the skid slot.
      skid_vld_d = 1'b1;
      skid_dat_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_dat_q <= skid_dat_d;
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign count     = {1'b0, out_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: rtl/bram_responder.sv
// Memory-side responder for the pe_con 32-bit BRAM port.
//   aclk, areset : clock and synchronous active-high reset
//   BRAM_*       : port A, pe_con reads and byte-masked writes,
//                  read-first, READ_LATENCY (1 or 2) cycles to BRAM_RDDATA;
//                  BRAM_RST zeroes the final output register
//   ld_*         : port B host preload, accepted only while the dump FSM idles
//   done         : rising edge starts a dump of DUMP_WORDS words from DUMP_BASE
//   dump_*       : valid/ready result stream, dump_last marks the final word
//   busy         : dump FSM not idle
module bram_responder
  import bram_responder_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int READ_LATENCY    = 1,
  parameter int DUMP_BASE       = 0,
  parameter int DUMP_WORDS      = 64
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic                       BRAM_EN,
  input  logic                       BRAM_RST,
  input  logic [BYTE_LANES-1:0]      BRAM_WE,
  input  logic [DATA_W-1:0]          BRAM_WRDATA,
  output logic [DATA_W-1:0]          BRAM_RDDATA,
  input  logic                       done,
  input  logic                       ld_valid,
  input  logic [BRAM_ADDR_WIDTH-3:0] ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [DATA_W-1:0]          dump_data,
  output logic                       dump_last,
  output logic                       busy
);

  localparam int IDX_W = BRAM_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = $clog2(DUMP_WORDS + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  a_idx;
  logic [DATA_W-1:0] a_s1_q;

  dump_state_e       state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              b_vld_q;
  logic              b_last_q;
  logic [DATA_W-1:0] b_rd_q;

  logic              done_rise;
  logic              b_we;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic [1:0]        skid_cnt;
  logic [2:0]        occ;

  assign a_idx      = IDX_W'(word_index(32'(BRAM_ADDR)));
  assign done_rise  = done & ~done_q;
  assign b_we       = ld_valid && (state_q == ST_IDLE);
  assign pop        = dump_valid & dump_ready;
  assign last_issue = (cnt_q == CNT_W'(DUMP_WORDS - 1));

  // Words buffered plus the one possibly in flight from the RAM. A read
  // may be issued only if that word will still find room when it lands.
  assign occ   = {1'b0, skid_cnt} + {2'b0, b_vld_q};
  assign issue = (state_q == ST_DUMP) && ((occ < 3'd2) || ((occ == 3'd2) && pop));

  // True dual-port RAM. Port B is listed first so that a same-word,
  // same-cycle port A write lands last and wins.
  always_ff @(posedge aclk) begin
    if (b_we) begin
      mem[ld_addr] <= ld_data;
    end
    if (issue) begin
      b_rd_q <= mem[ptr_q];
    end
    if (BRAM_EN) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (BRAM_WE[i]) begin
          mem[a_idx][8*i +: 8] <= BRAM_WRDATA[8*i +: 8];
        end
      end
    end
  end

  // Port A first read stage; it is also the final stage at latency 1, so
  // BRAM_RST clears it only in that configuration.
  always_ff @(posedge aclk) begin
    if (areset || ((READ_LATENCY == 1) && BRAM_RST)) begin
      a_s1_q <= '0;
    end else if (BRAM_EN) begin
      a_s1_q <= mem[a_idx];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              en1_q;
      logic [DATA_W-1:0] a_s2_q;

      // Output register advances only when the stage before it was loaded.
      always_ff @(posedge aclk) begin
        if (areset) begin
          en1_q  <= 1'b0;
          a_s2_q <= '0;
        end else begin
          en1_q <= BRAM_EN;
          if (BRAM_RST) begin
            a_s2_q <= '0;
          end else if (en1_q) begin
            a_s2_q <= a_s1_q;
          end
        end
      end

      assign BRAM_RDDATA = a_s2_q;
    end else begin : g_lat1
      assign BRAM_RDDATA = a_s1_q;
    end
  endgenerate

  // Dump FSM plus the port-B read-valid tag that rides alongside b_rd_q.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      b_vld_q  <= 1'b0;
      b_last_q <= 1'b0;
    end else begin
      done_q   <= done;
      b_vld_q  <= issue;
      b_last_q <= issue && last_issue;
      case (state_q)
        ST_IDLE: begin
          if (done_rise) begin
            state_q <= ST_DUMP;
            ptr_q   <= IDX_W'(DUMP_BASE);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (issue) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
            if (last_issue) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && dump_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  bram_skid_buffer #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk       (aclk),
    .rst       (areset),
    .in_valid  (b_vld_q),
    .in_data   ({b_last_q, b_rd_q}),
    .out_valid (dump_valid),
    .out_ready (dump_ready),
    .out_data  ({dump_last, dump_data}),
    .count     (skid_cnt)
  );

endmodule

// File: tb/tb_bram_responder.sv
// Self-checking bench for bram_responder: table-driven port A/preload
// vectors plus hand-written dump sequences.
module tb_bram_responder;

  localparam int AW = 15;
  localparam int NW = 64;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] BRAM_ADDR;
  logic          BRAM_EN, BRAM_RST;
  logic [3:0]    BRAM_WE;
  logic [31:0]   BRAM_WRDATA, BRAM_RDDATA, rd2;
  logic          done, ld_valid;
  logic [AW-3:0] ld_addr;
  logic [31:0]   ld_data;
  logic          dump_valid, dump_ready, dump_last, busy;
  logic [31:0]   dump_data;
  logic          dv2, dl2, busy2;
  logic [31:0]   dd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  bram_responder #(.BRAM_ADDR_WIDTH(AW), .READ_LATENCY(1), .DUMP_BASE(0), .DUMP_WORDS(NW)) u_dut (
    .aclk(aclk), .areset(areset), .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN),
    .BRAM_RST(BRAM_RST), .BRAM_WE(BRAM_WE), .BRAM_WRDATA(BRAM_WRDATA),
    .BRAM_RDDATA(BRAM_RDDATA), .done(done), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_last(dump_last), .busy(busy)
  );

  bram_responder #(.BRAM_ADDR_WIDTH(AW), .READ_LATENCY(2), .DUMP_BASE(0), .DUMP_WORDS(NW)) u_dut2 (
    .aclk(aclk), .areset(areset), .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN),
    .BRAM_RST(BRAM_RST), .BRAM_WE(BRAM_WE), .BRAM_WRDATA(BRAM_WRDATA),
    .BRAM_RDDATA(rd2), .done(done), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .dump_valid(dv2), .dump_ready(dump_ready),
    .dump_data(dd2), .dump_last(dl2), .busy(busy2)
  );

  typedef struct {
    logic          ld_v;
    logic [AW-3:0] ld_a;
    logic [31:0]   ld_d;
    logic          en;
    logic          rst;
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          c1;
    logic [31:0]   e1;
    logic          c2;
    logic [31:0]   e2;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Starts a dump with a done edge and consumes it. rnd: random ready.
  // rst_at >= 0: pulse areset once that many beats were accepted.
  // glitch: a second done edge and an ignored preload during the dump.
  task automatic do_dump(input bit rnd, input int rst_at, input bit glitch);
    int          beats;
    int          cyc;
    bit          rdy;
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    beats      = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    dump_ready = 1'b1;
    done       = 1'b1;
    tick;
    check("busy_after_edge", 32'(busy), 32'd1);
    check("valid_edge_plus1", 32'(dump_valid), 32'd0);
    tick;
    check("valid_edge_plus2_low", 32'(dump_valid), 32'd0);
    tick;
    check("first_valid_latency", 32'(dump_valid), 32'd1);
    while (beats < NW && cyc < 2000) begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(dump_valid), 32'd1);
        check("stall_data_stable", dump_data, prev_d);
        check("stall_last_stable", 32'(dump_last), 32'(prev_l));
      end
      rdy = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      if (glitch) begin
        if (beats == 20) done = 1'b0;
        if (beats == 30) done = 1'b1;
        ld_valid = (beats == 5);
        ld_addr  = 13'd3;
        ld_data  = 32'hFFFF_FFFF;
      end
      if (rst_at >= 0 && beats == rst_at) begin
        areset     = 1'b1;
        done       = 1'b0;
        dump_ready = rdy;
        tick;
        areset = 1'b0;
        check("reset_mid_dump_valid", 32'(dump_valid), 32'd0);
        check("reset_mid_dump_busy", 32'(busy), 32'd0);
        tick;
        return;
      end
      dump_ready = rdy;
      if (dump_valid && rdy) begin
        check($sformatf("beat%0d_data", beats), dump_data, 32'(beats));
        check($sformatf("beat%0d_last", beats), 32'(dump_last), 32'(beats == NW - 1));
        beats++;
      end
      prev_stall = dump_valid && !rdy;
      prev_d     = dump_data;
      prev_l     = dump_last;
      tick;
      cyc++;
    end
    ld_valid = 1'b0;
    if (cyc >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL dump_timeout: got %0d beats expected %0d", beats, NW);
    end
    if (!rnd) check("dump_no_gaps_cycles", 32'(cyc), 32'(NW));
    check("busy_after_last", 32'(busy), 32'd0);
    check("valid_after_last", 32'(dump_valid), 32'd0);
    done = 1'b0;
    tick;
    tick;
    check("no_extra_dump_valid", 32'(dump_valid), 32'd0);
    check("no_extra_dump_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    areset      = 1'b1;
    BRAM_ADDR   = '0;
    BRAM_EN     = 1'b0;
    BRAM_RST    = 1'b0;
    BRAM_WE     = 4'h0;
    BRAM_WRDATA = '0;
    done        = 1'b0;
    ld_valid    = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    dump_ready  = 1'b0;

    //             ld_v ld_a    ld_d           en rst we    addr     wd             c1 e1             c2 e2
    tbl[0]  = '{1'b1, 13'd5, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 15'h00, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    tbl[1]  = '{1'b1, 13'd6, 32'h01020304, 1'b0, 1'b0, 4'h0, 15'h00, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    tbl[2]  = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'h0, 15'h14, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'h5, 15'h14, 32'h11223344, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    tbl[4]  = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'h0, 15'h14, 32'h0,        1'b1, 32'hDE22BE44, 1'b1, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'h0, 15'h18, 32'h0,        1'b1, 32'h01020304, 1'b1, 32'hDE22BE44};
    tbl[6]  = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b1, 4'h0, 15'h14, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    tbl[7]  = '{1'b0, 13'd0, 32'h0,        1'b0, 1'b0, 4'h0, 15'h14, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    tbl[8]  = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'hF, 15'h18, 32'hCAFEF00D, 1'b1, 32'h01020304, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'h0, 15'h19, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 13'd0, 32'h0,        1'b0, 1'b0, 4'hF, 15'h18, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'h0, 15'h18, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b1, 4'h8, 15'h18, 32'hAB000000, 1'b1, 32'h0,        1'b0, 32'h0};
    tbl[13] = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'h0, 15'h18, 32'h0,        1'b1, 32'hABFEF00D, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 13'd7, 32'h55555555, 1'b1, 1'b0, 4'hF, 15'h1C, 32'h77777777, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[15] = '{1'b0, 13'd0, 32'h0,        1'b1, 1'b0, 4'h0, 15'h1C, 32'h0,        1'b1, 32'h77777777, 1'b0, 32'h0};

    repeat (3) tick;
    areset = 1'b0;
    check("reset_rddata", BRAM_RDDATA, 32'h0);
    check("reset_rddata_lat2", rd2, 32'h0);
    check("reset_dump_valid", 32'(dump_valid), 32'd0);
    check("reset_dump_data", dump_data, 32'h0);
    check("reset_dump_last", 32'(dump_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      ld_valid    = tbl[i].ld_v;
      ld_addr     = tbl[i].ld_a;
      ld_data     = tbl[i].ld_d;
      BRAM_EN     = tbl[i].en;
      BRAM_RST    = tbl[i].rst;
      BRAM_WE     = tbl[i].we;
      BRAM_ADDR   = tbl[i].addr;
      BRAM_WRDATA = tbl[i].wd;
      tick;
      if (tbl[i].c1) check($sformatf("vec%0d_rddata", i), BRAM_RDDATA, tbl[i].e1);
      if (tbl[i].c2) check($sformatf("vec%0d_rddata_lat2", i), rd2, tbl[i].e2);
    end
    ld_valid = 1'b0;
    BRAM_EN  = 1'b0;
    BRAM_RST = 1'b0;
    BRAM_WE  = 4'h0;

    for (int i = 0; i < NW; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 13'(i);
      ld_data  = 32'(i);
      tick;
    end
    ld_valid = 1'b0;
    tick;

    do_dump(1'b0, -1, 1'b0);
    do_dump(1'b1, -1, 1'b1);

    // The preload attempted mid-dump must not have landed.
    BRAM_EN   = 1'b1;
    BRAM_ADDR = 15'h0C;
    tick;
    BRAM_EN = 1'b0;
    check("busy_preload_ignored", BRAM_RDDATA, 32'd3);

    do_dump(1'b0, 10, 1'b0);
    do_dump(1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
